// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// The master issues and holds a request; the slave answers with ack and read data.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores, formats byte lanes and load data,
// stalls upstream while an access is outstanding, and registers MEM/WB outputs.
module mem_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            in_valid,
    input  logic            in_is_write_dmem,
    input  logic            in_is_write_rf,
    input  logic [1:0]      in_wb_select,
    input  logic [7:0]      in_write_width,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc_plus_4,
    input  logic [XLEN-1:0] in_now_pc,
    input  logic [ILEN-1:0] in_instruction,
    mem_stage_if.master     dmem,
    output logic            stall_req,
    output logic            out_valid,
    output logic            out_is_write_rf,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wb_data,
    output logic [XLEN-1:0] out_now_pc,
    output logic [ILEN-1:0] out_instruction,
    output logic            out_misaligned
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_stall;
    logic [2:0]      w_funct3;
    logic [1:0]      w_boff;
    logic            w_is_byte;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_mem_op;
    logic            w_misaligned;
    logic            w_issue;
    logic            w_out_fire;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_fmt;
    logic [XLEN-1:0] w_wb_val;
    logic [XLEN-1:0] r_load_data;

    // funct3[1:0] picks the access size; reserved encodings fall into word
    assign w_funct3     = in_write_width[2:0];
    assign w_boff       = in_alu_res[1:0];
    assign w_is_byte    = (w_funct3[1:0] == 2'b00);
    assign w_is_half    = (w_funct3[1:0] == 2'b01);
    assign w_is_word    = !w_is_byte && !w_is_half;
    assign w_mem_op     = in_valid && (in_is_write_dmem || in_wb_select == 2'b01);
    assign w_misaligned = (w_is_half && w_boff[0]) || (w_is_word && w_boff != 2'b00);
    assign w_issue      = w_mem_op && !w_misaligned;
    assign w_out_fire   = (r_state == S_DONE) || (r_state == S_IDLE && !w_issue);
    assign w_shifted    = dmem.rdata >> {w_boff, 3'b000};

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = in_rs2_data;
        if (w_is_byte) begin
            w_wstrb = 4'b0001 << w_boff;
            w_wdata = {4{in_rs2_data[7:0]}};
        end else if (w_is_half) begin
            w_wstrb = 4'b0011 << w_boff;
            w_wdata = {2{in_rs2_data[15:0]}};
        end
    end

    always_comb begin
        w_load_fmt = w_shifted;
        case (w_funct3)
            3'b000:  w_load_fmt = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_fmt = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_fmt = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_load_fmt = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: w_load_fmt = w_shifted;
        endcase
    end

    always_comb begin
        w_wb_val = in_alu_res;
        case (in_wb_select)
            2'b01:   w_wb_val = (r_state == S_DONE) ? r_load_data : '0;
            2'b10:   w_wb_val = in_pc_plus_4;
            default: w_wb_val = in_alu_res;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // stall is gated by reset so a held-over memory op cannot stall during reset
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: if (w_issue && sys_rst) begin
                w_stall     = 1'b1;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (dmem.ack) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        stall_req = w_stall;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            dmem.req    <= 1'b0;
            dmem.we     <= 1'b0;
            dmem.addr   <= '0;
            dmem.wdata  <= '0;
            dmem.wstrb  <= '0;
            r_load_data <= '0;
        end else if (r_state == S_IDLE && w_issue) begin
            dmem.req   <= 1'b1;
            dmem.we    <= in_is_write_dmem;
            dmem.addr  <= {in_alu_res[XLEN-1:2], 2'b00};
            dmem.wdata <= w_wdata;
            dmem.wstrb <= w_wstrb;
        end else if (r_state == S_BUSY && dmem.ack) begin
            dmem.req    <= 1'b0;
            r_load_data <= w_load_fmt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            out_valid       <= 1'b0;
            out_is_write_rf <= 1'b0;
            out_rd          <= '0;
            out_wb_data     <= '0;
            out_now_pc      <= '0;
            out_instruction <= '0;
            out_misaligned  <= 1'b0;
        end else if (w_out_fire) begin
            out_valid       <= in_valid;
            out_is_write_rf <= in_valid && in_is_write_rf && !(w_mem_op && w_misaligned);
            out_misaligned  <= w_mem_op && w_misaligned;
            out_rd          <= in_rd;
            out_wb_data     <= w_wb_val;
            out_now_pc      <= in_now_pc;
            out_instruction <= in_instruction;
        end else begin
            out_valid       <= 1'b0;
            out_is_write_rf <= 1'b0;
            out_misaligned  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misalignment, reset abort.
module tb_mem_stage;
    localparam int XLEN = 32;
    localparam int ILEN = 32;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_is_write_dmem = 1'b0;
    logic            in_is_write_rf = 1'b0;
    logic [1:0]      in_wb_select = 2'b00;
    logic [7:0]      in_write_width = 8'h0;
    logic [XLEN-1:0] in_rs2_data = '0;
    logic [XLEN-1:0] in_alu_res = '0;
    logic [4:0]      in_rd = '0;
    logic [XLEN-1:0] in_pc_plus_4 = '0;
    logic [XLEN-1:0] in_now_pc = '0;
    logic [ILEN-1:0] in_instruction = '0;
    logic            stall_req;
    logic            out_valid;
    logic            out_is_write_rf;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_wb_data;
    logic [XLEN-1:0] out_now_pc;
    logic [ILEN-1:0] out_instruction;
    logic            out_misaligned;

    int total = 0;
    int bad   = 0;

    mem_stage_if #(.XLEN(XLEN)) dmem_bus ();

    mem_stage #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_is_write_dmem(in_is_write_dmem),
        .in_is_write_rf(in_is_write_rf), .in_wb_select(in_wb_select),
        .in_write_width(in_write_width), .in_rs2_data(in_rs2_data),
        .in_alu_res(in_alu_res), .in_rd(in_rd), .in_pc_plus_4(in_pc_plus_4),
        .in_now_pc(in_now_pc), .in_instruction(in_instruction),
        .dmem(dmem_bus.master), .stall_req(stall_req),
        .out_valid(out_valid), .out_is_write_rf(out_is_write_rf),
        .out_rd(out_rd), .out_wb_data(out_wb_data), .out_now_pc(out_now_pc),
        .out_instruction(out_instruction), .out_misaligned(out_misaligned)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_op(input logic st, input logic wrf, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd);
        in_valid         = 1'b1;
        in_is_write_dmem = st;
        in_is_write_rf   = wrf;
        in_wb_select     = sel;
        in_write_width   = {5'b10101, f3};
        in_alu_res       = addr;
        in_rs2_data      = rs2;
        in_rd            = rd;
        in_now_pc        = 32'h0000_0400;
        in_pc_plus_4     = 32'h0000_0404;
        in_instruction   = 32'h0000_0013;
    endtask

    task automatic test_reset();
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        #2;
        total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dmem_bus.req); end
        total++; if (dmem_bus.addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", dmem_bus.addr); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        total++; if (out_valid !== 1'b0 || out_wb_data !== 32'h0) begin bad++; $display("FAIL reset_out got=%b/%h exp=0/0", out_valid, out_wb_data); end
        tick(); tick();
        sys_rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        set_op(1'b0, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd5);
        in_now_pc = 32'h0000_0080; in_instruction = 32'h0062_8293;
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall_req); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", out_valid); end
        total++; if (out_wb_data !== 32'h1234) begin bad++; $display("FAIL alu_wb got=%h exp=00001234", out_wb_data); end
        total++; if (out_rd !== 5'd5 || out_is_write_rf !== 1'b1) begin bad++; $display("FAIL alu_rd got=%0d/%b exp=5/1", out_rd, out_is_write_rf); end
        total++; if (out_now_pc !== 32'h80 || out_instruction !== 32'h0062_8293) begin bad++; $display("FAIL alu_pc got=%h/%h exp=00000080/00628293", out_now_pc, out_instruction); end
        total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL alu_req got=%b exp=0", dmem_bus.req); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_lb();
        set_op(1'b0, 1'b1, 2'b01, 3'b000, 32'h103, 32'h0, 5'd7);
        #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL lb_stall0 got=%b exp=1", stall_req); end
        tick();
        total++; if (dmem_bus.req !== 1'b1 || dmem_bus.we !== 1'b0) begin bad++; $display("FAIL lb_req1 got=%b/%b exp=1/0", dmem_bus.req, dmem_bus.we); end
        total++; if (dmem_bus.addr !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h exp=00000100", dmem_bus.addr); end
        total++; if (stall_req !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL lb_busy1 got=%b/%b exp=1/0", stall_req, out_valid); end
        tick();
        total++; if (dmem_bus.req !== 1'b1 || stall_req !== 1'b1) begin bad++; $display("FAIL lb_busy2 got=%b/%b exp=1/1", dmem_bus.req, stall_req); end
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h80FF_0000;
        tick();
        dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'hDEAD_BEEF;
        total++; if (dmem_bus.req !== 1'b0 || stall_req !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL lb_done got=%b/%b/%b exp=0/0/0", dmem_bus.req, stall_req, out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_wb_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_wb got=%b/%h exp=1/ffffff80", out_valid, out_wb_data); end
        total++; if (out_is_write_rf !== 1'b1 || out_rd !== 5'd7) begin bad++; $display("FAIL lb_rf got=%b/%0d exp=1/7", out_is_write_rf, out_rd); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lb_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_lhu();
        set_op(1'b0, 1'b1, 2'b01, 3'b101, 32'h102, 32'h0, 5'd9);
        tick();
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h8001_1234;
        tick();
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        total++; if (dmem_bus.req !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL lhu_done got=%b/%b exp=0/0", dmem_bus.req, out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_wb_data !== 32'h0000_8001) begin bad++; $display("FAIL lhu_wb got=%b/%h exp=1/00008001", out_valid, out_wb_data); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_store();
        set_op(1'b1, 1'b0, 2'b00, 3'b000, 32'h201, 32'hAABB_CCDD, 5'd0);
        tick();
        total++; if (dmem_bus.we !== 1'b1 || dmem_bus.wstrb !== 4'b0010) begin bad++; $display("FAIL sb_strb got=%b/%b exp=1/0010", dmem_bus.we, dmem_bus.wstrb); end
        total++; if (dmem_bus.wdata !== 32'hDDDD_DDDD || dmem_bus.addr !== 32'h200) begin bad++; $display("FAIL sb_data got=%h/%h exp=dddddddd/00000200", dmem_bus.wdata, dmem_bus.addr); end
        dmem_bus.ack = 1'b1;
        tick();
        dmem_bus.ack = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || out_is_write_rf !== 1'b0) begin bad++; $display("FAIL sb_out got=%b/%b exp=1/0", out_valid, out_is_write_rf); end
        set_op(1'b1, 1'b0, 2'b00, 3'b001, 32'h202, 32'h1122_3344, 5'd0);
        tick();
        total++; if (dmem_bus.wstrb !== 4'b1100 || dmem_bus.wdata !== 32'h3344_3344) begin bad++; $display("FAIL sh_lane got=%b/%h exp=1100/33443344", dmem_bus.wstrb, dmem_bus.wdata); end
        dmem_bus.ack = 1'b1;
        tick();
        dmem_bus.ack = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        set_op(1'b0, 1'b1, 2'b01, 3'b010, 32'h102, 32'h0, 5'd3);
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b exp=0", stall_req); end
        tick();
        total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", dmem_bus.req); end
        total++; if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_is_write_rf !== 1'b0) begin bad++; $display("FAIL mis_out got=%b/%b/%b exp=1/1/0", out_valid, out_misaligned, out_is_write_rf); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 5'd1);
        tick();
        total++; if (out_valid !== 1'b1 || out_wb_data !== 32'h55) begin bad++; $display("FAIL b2b_alu got=%b/%h exp=1/00000055", out_valid, out_wb_data); end
        set_op(1'b0, 1'b1, 2'b10, 3'b000, 32'h99, 32'h0, 5'd2);
        tick();
        total++; if (out_valid !== 1'b1 || out_wb_data !== 32'h404 || out_rd !== 5'd2) begin bad++; $display("FAIL b2b_jal got=%b/%h/%0d exp=1/00000404/2", out_valid, out_wb_data, out_rd); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        set_op(1'b0, 1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 5'd4);
        tick();
        total++; if (dmem_bus.req !== 1'b1) begin bad++; $display("FAIL rb_req got=%b exp=1", dmem_bus.req); end
        sys_rst = 1'b0;
        #1;
        total++; if (dmem_bus.req !== 1'b0 || stall_req !== 1'b0) begin bad++; $display("FAIL rb_abort got=%b/%b exp=0/0", dmem_bus.req, stall_req); end
        in_valid = 1'b0;
        tick();
        sys_rst = 1'b1;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h1234_5678;
        tick();
        dmem_bus.ack = 1'b0;
        total++; if (dmem_bus.req !== 1'b0 || out_valid !== 1'b0 || stall_req !== 1'b0) begin bad++; $display("FAIL rb_lateack got=%b/%b/%b exp=0/0/0", dmem_bus.req, out_valid, stall_req); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rb_noout got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_lhu();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
